// File: rtl/eth_8b10b_tx_encoder.sv
// Transmit-side 8b/10b encoder for the tri-mode Ethernet PCS.
// One byte plus a symbol-select code in, one 10-bit code-group out per cycle,
// with running-disparity tracking and an autonomous /I1/ /I2/ idle generator.
module eth_8b10b_tx_encoder #(
    parameter bit RD_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] txd,
    input  logic [3:0] tx_enc_ctrl_sel,
    output logic       in_ready,
    output logic [9:0] tx_10bdata,
    output logic       tx_rd,
    output logic       code_err
);

    typedef enum logic {
        ST_DATA  = 1'b0,
        ST_IDLE2 = 1'b1
    } state_t;

    localparam logic [3:0] SEL_DATA  = 4'b0000;
    localparam logic [3:0] SEL_K28_5 = 4'b0001;
    localparam logic [3:0] SEL_S     = 4'b0010;
    localparam logic [3:0] SEL_T     = 4'b0011;
    localparam logic [3:0] SEL_R     = 4'b0100;
    localparam logic [3:0] SEL_V     = 4'b0101;
    localparam logic [3:0] SEL_IDLE  = 4'b1000;

    state_t      r_state;
    logic [3:0]  r_sel;
    logic [7:0]  r_txd;
    logic [9:0]  r_tx10;
    logic        r_rd;
    logic        r_err;

    logic        w_is_k;
    logic [4:0]  w_x;
    logic [2:0]  w_y;
    logic        w_err;
    logic [10:0] w_enc;
    logic [9:0]  w_wire;

    // 5b/6b table, RD- column, written abcdei (a in the MSB)
    function automatic logic [5:0] tbl_6b(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b data table, RD- column, fghj (f in the MSB); y=7 is the primary P7
    function automatic logic [3:0] tbl_4b_data(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    // 3b/4b control table, RD- column; every K entry flips for RD+
    function automatic logic [3:0] tbl_4b_k(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b0110;
            3'd2:    c = 4'b1010;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b0101;
            3'd6:    c = 4'b1001;
            default: c = 4'b0111;
        endcase
        return c;
    endfunction

    function automatic logic rd_after_6b(input logic [5:0] c, input logic rd_in);
        int ones;
        ones = $countones(c);
        if (ones > 3)            return 1'b1;
        else if (ones < 3)       return 1'b0;
        else if (c == 6'b000111) return 1'b1;
        else if (c == 6'b111000) return 1'b0;
        else                     return rd_in;
    endfunction

    function automatic logic rd_after_4b(input logic [3:0] c, input logic rd_in);
        int ones;
        ones = $countones(c);
        if (ones > 2)          return 1'b1;
        else if (ones < 2)     return 1'b0;
        else if (c == 4'b0011) return 1'b1;
        else if (c == 4'b1100) return 1'b0;
        else                   return rd_in;
    endfunction

    // Returns {rd_after, abcdei, fghj}; the 4b half uses the RD left by the 6b half
    function automatic logic [10:0] encode_8b10b(input logic       is_k,
                                                 input logic [4:0] x,
                                                 input logic [2:0] y,
                                                 input logic       rd_in);
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd6;
        logic       rd4;
        logic       alt7;
        c6 = (is_k && x == 5'd28) ? 6'b001111 : tbl_6b(x);
        if (rd_in && (is_k || $countones(c6) != 3 || x == 5'd7)) c6 = ~c6;
        rd6 = rd_after_6b(c6, rd_in);
        // A7 avoids a run of five equal bits across the e/i - f/g boundary
        alt7 = !is_k && (y == 3'd7) &&
               ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        if (is_k)      c4 = tbl_4b_k(y);
        else if (alt7) c4 = 4'b0111;
        else           c4 = tbl_4b_data(y);
        if (rd6 && (is_k || alt7 || $countones(c4) != 2 || y == 3'd3)) c4 = ~c4;
        rd4 = rd_after_4b(c4, rd6);
        return {rd4, c6, c4};
    endfunction

    assign in_ready   = !((r_state == ST_DATA) && (r_sel == SEL_IDLE));
    assign tx_10bdata = r_tx10;
    assign tx_rd      = r_rd;
    assign code_err   = r_err;

    // Pick the symbol to encode this cycle from the FSM state and stage S1
    always_comb begin
        w_is_k = 1'b0;
        w_x    = r_txd[4:0];
        w_y    = r_txd[7:5];
        w_err  = 1'b0;
        if (r_state == ST_IDLE2) begin
            // r_rd already holds the RD left by the K28.5 of this pair
            if (r_rd) begin
                w_x = 5'd16;
                w_y = 3'd2;
            end else begin
                w_x = 5'd5;
                w_y = 3'd6;
            end
        end else begin
            case (r_sel)
                SEL_DATA: ;
                SEL_K28_5, SEL_IDLE: begin
                    w_is_k = 1'b1; w_x = 5'd28; w_y = 3'd5;
                end
                SEL_S: begin
                    w_is_k = 1'b1; w_x = 5'd27; w_y = 3'd7;
                end
                SEL_T: begin
                    w_is_k = 1'b1; w_x = 5'd29; w_y = 3'd7;
                end
                SEL_R: begin
                    w_is_k = 1'b1; w_x = 5'd23; w_y = 3'd7;
                end
                SEL_V: begin
                    w_is_k = 1'b1; w_x = 5'd30; w_y = 3'd7;
                end
                default: begin
                    w_is_k = 1'b1; w_x = 5'd30; w_y = 3'd7; w_err = 1'b1;
                end
            endcase
        end
    end

    // Encode with the current RD and reorder to wire order (bit0 = a)
    always_comb begin
        w_enc  = encode_8b10b(w_is_k, w_x, w_y, r_rd);
        w_wire = {w_enc[0], w_enc[1], w_enc[2], w_enc[3], w_enc[4],
                  w_enc[5], w_enc[6], w_enc[7], w_enc[8], w_enc[9]};
    end

    // Input stage, idle FSM, output register and RD flop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_DATA;
            r_sel   <= SEL_IDLE;
            r_txd   <= 8'h00;
            r_tx10  <= 10'd0;
            r_rd    <= RD_INIT;
            r_err   <= 1'b0;
        end else begin
            if (in_ready) begin
                r_sel <= tx_enc_ctrl_sel;
                r_txd <= txd;
            end
            r_tx10 <= w_wire;
            r_rd   <= w_enc[10];
            r_err  <= w_err;
            case (r_state)
                ST_DATA:  if (r_sel == SEL_IDLE) r_state <= ST_IDLE2;
                default:  r_state <= ST_DATA;
            endcase
        end
    end

endmodule
